ctr_packer: RTL
===============

# ctr_packer

Downstream stage of the Mandelbrot iteration engine. It takes the 4-bit per-pixel iteration counts (`ctr_in` qualified by the `new_ctr` strobe, arriving in raster order) and packs each consecutive pair into one byte. Bytes are buffered in a small FIFO and presented on a valid/ready byte interface to the chip I/O. The block tags the first byte of each frame, counts pixels to flag frame end, and records a sticky overflow when the consumer falls behind. The engine cannot stall, so this buffering is required.

## Interface
- `DEPTH`, 4, FIFO depth in bytes; power of two, at least 2.
- `PIXELS`, 640*480, pixels per frame; must be even.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `running`  in  1  engine running flag; its rising edge starts a frame.
- `ctr_in`  in  4  iteration count of the current pixel.
- `new_ctr`  in  1  one-cycle strobe qualifying `ctr_in`.
- `out_data`  out  8  head byte of the FIFO.
- `out_first`  out  1  head byte is the first byte of a frame.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head byte this cycle.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a byte was dropped this frame.
- `frame_done`  out  1  one-cycle pulse after the last pair of a frame is processed.

## Operation
- **Reset** (asynchronous, immediate) clears the following state:
  - `level`=0, `out_valid`=0, `out_first`=0, `overflow`=0, `frame_done`=0.
  - Half-byte flag cleared, pixel counter 0, first-pending 0, registered `running` = 0.
  - `out_data` is don't-care while `out_valid`=0.
- **Frame start**: detected when `running`=1 and the registered `running`=0. On that edge:
  - The half-byte flag and pixel counter clear.
  - `overflow` clears.
  - first-pending sets.
  - FIFO contents are kept; the previous frame's tail still drains.
  - If `new_ctr` occurs in the same cycle, it counts as pixel 0 of the new frame.
- **Strobe acceptance**: `new_ctr` is accepted regardless of `running`. The engine's final strobe arrives after `running` falls.
- **Packing**:
  - First strobe of a pair: latch `ctr_in` into the holding nibble and set the half flag.
  - Second strobe: push byte {held nibble, `ctr_in`}, so the earlier pixel sits in bits [7:4]. Clear the half flag.
- **First-byte tag**: each FIFO entry is 9 bits (byte plus first tag). The tag equals first-pending at push time. First-pending clears on the push attempt, whether the byte is accepted or dropped.
- **Push acceptance**: a push is accepted if `level`<DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
  - The pixel counter advances in either case, so frame alignment is preserved.
- **Pop**: occurs when `out_valid` && `out_ready`. With a simultaneous push and pop, `level` is unchanged.
- **Pixel counter**: counts 0..PIXELS-1 and increments on each accepted strobe.
  - On the strobe where the counter is PIXELS-1, it wraps to 0 and `frame_done` pulses on the next cycle.
  - No further frame logic follows; the next frame requires a new `running` rising edge.
- **Arithmetic**: counter width is $clog2(PIXELS). FIFO pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- **Push latency**: a byte pushed at edge N into an empty FIFO shows `out_valid`=1 with the correct `out_data`/`out_first` after edge N.
- **Head stability**: `out_data` and `out_first` are driven combinationally from the head entry. They stay stable while `out_valid`=1 and `out_ready`=0.
- **Throughput**: one pop per cycle sustained. The input produces at most one byte every 2 cycles.
- **Handshake**: `out_ready` may toggle freely. `out_valid` never drops without a pop.
- **Timing of `level`, `overflow`, `frame_done`**: all are registered and update on the same edge as the push/pop that causes them.
- **Reset timing**: reset asserted mid-frame discards the held nibble and the FIFO. Outputs go to reset values without waiting for a clock edge.

## Test plan
- Reset, raise `running`, strobe 0x3 then 0xA → next cycle: `out_valid`=1, `out_data`=0x3A, `out_first`=1, `level`=1; pop → `level`=0.
- DEPTH=4, `out_ready`=0, push 5 bytes 0x01..0x05 (pixel pairs) → `level`=4, `overflow`=1 after the 5th; release ready → 0x01..0x04 in order, 0x05 absent.
- `level`=4, `out_ready`=1 in the cycle of a 5th push → push accepted, `level` stays 4, `overflow`=0.
- PIXELS=8, 8 strobes → 4 bytes, only the first tagged; `frame_done` pulses once, one cycle after the 8th strobe; a 9th/10th strobe pair without a new `running` edge → byte with `out_first`=0.
- Single strobe, then drop and re-raise `running` → nibble discarded, `overflow` cleared; the next pair yields a byte with `out_first`=1 and the new nibbles only.
- Assert `reset` asynchronously between clock edges with `level`=3 → `out_valid`, `level`, `overflow` read 0 before the next edge; after release, first pair packs normally.

Source files
------------

// File: rtl/ctr_packer_if.sv
// Byte stream from the pixel packer to the chip I/O: one head byte with its
// first-of-frame tag, qualified by valid and accepted by ready.
interface ctr_packer_if;
    logic [7:0] out_data;
    logic       out_first;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_first,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_first,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ctr_packer.sv
// Packs pairs of 4-bit iteration counts into bytes, buffers them in a small
// FIFO and presents them on a valid/ready stream. Tags the first byte of each
// frame, pulses frame_done after the last pixel and flags dropped bytes.
module ctr_packer #(
    parameter int DEPTH  = 4,
    parameter int PIXELS = 640*480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    running,
    input  logic [3:0]              ctr_in,
    input  logic                    new_ctr,
    ctr_packer_if.master            byte_bus,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(PIXELS);

    logic          run_q;
    logic          frame_start;
    logic          half;
    logic          half_eff;
    logic [3:0]    hold;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] cnt_eff;
    logic          first_pending;
    logic          first_eff;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          last_pixel;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    mem [DEPTH];

    // Head entry drives the stream directly; the tag is masked while empty.
    assign byte_bus.out_valid = (level != '0);
    assign byte_bus.out_data  = mem[rd_ptr][7:0];
    assign byte_bus.out_first = byte_bus.out_valid & mem[rd_ptr][8];

    // A frame start acts as if the pack/count state were already cleared,
    // so a strobe in that same cycle becomes pixel 0 of the new frame.
    always_comb begin
        frame_start = running & ~run_q;
        half_eff    = frame_start ? 1'b0 : half;
        cnt_eff     = frame_start ? '0 : pix_cnt;
        first_eff   = frame_start | first_pending;
        push        = new_ctr & half_eff;
        pop         = byte_bus.out_valid & byte_bus.out_ready;
        push_ok     = push & ((level < LW'(DEPTH)) | pop);
        last_pixel  = (cnt_eff == CW'(PIXELS - 1));
    end

    // Packing, pixel counting, first-byte tagging and overflow tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q         <= 1'b0;
            half          <= 1'b0;
            hold          <= 4'h0;
            pix_cnt       <= '0;
            first_pending <= 1'b0;
            overflow      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            run_q         <= running;
            frame_done    <= new_ctr & last_pixel;
            first_pending <= first_eff & ~push;
            if (new_ctr) begin
                half    <= ~half_eff;
                pix_cnt <= last_pixel ? '0 : cnt_eff + CW'(1);
                if (!half_eff) begin
                    hold <= ctr_in;
                end
            end else if (frame_start) begin
                half    <= 1'b0;
                pix_cnt <= '0;
            end
            if (frame_start) begin
                overflow <= 1'b0;
            end else if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage: tag bit above the packed byte, earlier pixel in [7:4].
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {first_eff, hold, ctr_in};
        end
    end
endmodule
